// File: rtl/ottochip_pkg.sv
// ---------------------------------------------------------------------------
// ottochip_pkg
//   Shared definitions for the Ottochip serial boot path.
//   - boot_state_t    : boot loader FSM state encoding
//   - BOOT_MAGIC      : sync word ("CAFE") that starts a load
//   - BOOT_ADDR_WIDTH : default instruction RAM word-address width
// ---------------------------------------------------------------------------
package ottochip_pkg;

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } boot_state_t;

   localparam logic [31:0] BOOT_MAGIC      = 32'h4341_4645;
   localparam int unsigned BOOT_ADDR_WIDTH = 10;

endpackage

// File: rtl/boot_word_assembler.sv
// ---------------------------------------------------------------------------
// boot_word_assembler
//   Packs a byte stream into 32-bit big-endian words (first byte = MSB).
//   Ports:
//     i_clock       system clock
//     i_reset_n     asynchronous active-low reset
//     i_byte_valid  byte strobe, i_byte_data holds a new byte
//     i_byte_data   received byte
//     i_clear       drop any partial word and restart at byte 0
//     o_word        assembled word (valid while o_word_valid is high)
//     o_word_valid  one-cycle pulse with the 4th byte of a word
// ---------------------------------------------------------------------------
module boot_word_assembler (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte_data,
   input  logic        i_clear,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [23:0] r_shift;
   logic [1:0]  r_cnt;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_byte_valid) begin
         r_shift <= {r_shift[15:0], i_byte_data};
         r_cnt   <= r_cnt + 2'd1;   // wraps to 0 after the 4th byte
      end
   end

   // The word is presented combinationally with its last byte so the
   // consumer can act on it in the same cycle the byte arrives.
   assign o_word       = {r_shift, i_byte_data};
   assign o_word_valid = i_byte_valid && !i_clear && (r_cnt == 2'd3);

endmodule

// File: rtl/ottochip_boot_loader.sv
// ---------------------------------------------------------------------------
// ottochip_boot_loader
//   Serial boot protocol engine between uart_rx and the instruction RAM
//   write port. Protocol: MAGIC, 32-bit word count N, then N program words,
//   all big-endian. Holds the CPU in reset until the load completes.
//   Ports:
//     clock       system clock
//     reset       asynchronous active-low reset
//     rx_valid    one-cycle strobe: rx_data holds a new byte
//     rx_data     received byte
//     mem_we      write request, held until mem_ready
//     mem_ready   RAM accepts the write this cycle when mem_we=1
//     mem_addr    word address of the write (0-based)
//     mem_wdata   word to write
//     cpu_rst_n   0 holds the CPU in reset, 1 releases it
//     boot_done   sticky: load finished
//     boot_error  sticky: last attempt aborted
// ---------------------------------------------------------------------------
module ottochip_boot_loader
   import ottochip_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = BOOT_ADDR_WIDTH,
   parameter logic [31:0] MAGIC          = BOOT_MAGIC,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  mem_we,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_rst_n,
   output logic                  boot_done,
   output logic                  boot_error
);

   localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

   boot_state_t           r_state;
   logic [31:0]           r_win;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic                  r_cpu_rst_n;
   logic                  r_boot_done;
   logic                  r_boot_error;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic [IDLE_W-1:0]     r_idle;

   logic        w_in_load;
   logic [31:0] w_new_win;
   logic [31:0] w_word;
   logic        w_word_valid;
   logic        w_timeout;
   logic        w_wr_done;
   logic        w_last_wr;

   assign w_in_load = (r_state == ST_COUNT) || (r_state == ST_DATA);
   assign w_new_win = {r_win[23:0], rx_data};
   // A byte arriving in the expiry cycle wins over the timeout.
   assign w_timeout = w_in_load && !rx_valid &&
                      (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
   assign w_wr_done = r_mem_we && mem_ready;
   assign w_last_wr = w_wr_done && (r_remaining == (ADDR_WIDTH + 1)'(1));

   // Assembler only sees bytes while a load is in progress; it is held
   // clear in HUNT/ERROR/DONE so each load starts on a word boundary.
   boot_word_assembler u_asm (
      .i_clock      (clock),
      .i_reset_n    (reset),
      .i_byte_valid (rx_valid && w_in_load),
      .i_byte_data  (rx_data),
      .i_clear      (!w_in_load),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_HUNT;
         r_win        <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_rst_n  <= 1'b0;
         r_boot_done  <= 1'b0;
         r_boot_error <= 1'b0;
         r_remaining  <= '0;
         r_idle       <= '0;
      end else begin
         if (rx_valid || !w_in_load)
            r_idle <= '0;
         else if (!w_timeout)
            r_idle <= r_idle + IDLE_W'(1);

         case (r_state)
            ST_HUNT: begin
               if (rx_valid) begin
                  r_win <= w_new_win;
                  if (w_new_win == MAGIC) begin
                     r_boot_error <= 1'b0;
                     r_state      <= ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               if (w_timeout) begin
                  r_state <= ST_ERROR;
               end else if (w_word_valid) begin
                  if (w_word == '0) begin
                     r_state <= ST_DONE;
                  end else if (w_word > MAX_WORDS) begin
                     r_state <= ST_ERROR;
                  end else begin
                     r_remaining <= w_word[ADDR_WIDTH:0];
                     r_mem_addr  <= '0;
                     r_state     <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_timeout || (w_word_valid && r_mem_we && !mem_ready)) begin
                  r_mem_we <= 1'b0;
                  r_state  <= ST_ERROR;
               end else begin
                  if (w_wr_done) begin
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= r_mem_addr + ADDR_WIDTH'(1);
                     r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
                     if (w_last_wr)
                        r_state <= ST_DONE;
                  end
                  // A new word may land in the same cycle the previous write
                  // completes; the final write closes the load instead.
                  if (w_word_valid && !w_last_wr) begin
                     r_mem_wdata <= w_word;
                     r_mem_we    <= 1'b1;
                  end
               end
            end
            ST_ERROR: begin
               r_boot_error <= 1'b1;
               r_mem_we     <= 1'b0;
               r_win        <= '0;
               r_remaining  <= '0;
               r_state      <= ST_HUNT;
            end
            ST_DONE: begin
               r_cpu_rst_n <= 1'b1;
               r_boot_done <= 1'b1;
            end
            default: r_state <= ST_HUNT;
         endcase
      end
   end

   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign cpu_rst_n  = r_cpu_rst_n;
   assign boot_done  = r_boot_done;
   assign boot_error = r_boot_error;

endmodule

// File: tb/tb_ottochip_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_ottochip_boot_loader
//   Directed stimulus with a write scoreboard: expected RAM writes are queued
//   as bytes are sent, and a monitor pops one entry per completed write.
// ---------------------------------------------------------------------------
module tb_ottochip_boot_loader;

   localparam int unsigned AW    = 10;
   localparam int unsigned TO    = 1000;
   localparam logic [31:0] MAGIC = 32'h4341_4645;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          mem_ready = 1'b1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_rst_n;
   logic          boot_done;
   logic          boot_error;

   always #5 clock = ~clock;

   ottochip_boot_loader #(
      .ADDR_WIDTH     (AW),
      .MAGIC          (MAGIC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .mem_we     (mem_we),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .boot_done  (boot_done),
      .boot_error (boot_error)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks   = 0;
   int  failures = 0;
   int  n_writes = 0;

   logic [31:0] prog [8] = '{32'h00000013, 32'h20000137, 32'h02010113, 32'h00800193,
                             32'h00012223, 32'h00012023, 32'h00312023, 32'hff9ff06f};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a write completes on the edge after a cycle with mem_we && mem_ready.
   always @(negedge clock) begin
      if (reset && mem_we && mem_ready) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
            check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clock); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clock); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic expect_word(input int unsigned addr, input logic [31:0] w);
      exp_q.push_back('{addr: AW'(addr), data: w});
      send_word(w);
   endtask

   task automatic wait_writes(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (n_writes >= target) break;
         @(posedge clock); #2;
      end
      check("writes_seen", 64'(n_writes), 64'(target));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      rx_valid  = 1'b0;
      mem_ready = 1'b1;
      reset     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset    = 1'b1;
      n_writes = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_we"},     64'(mem_we),     64'd0);
      check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
      check({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
      check({tag, "_cpu_rst_n"},  64'(cpu_rst_n),  64'd0);
      check({tag, "_boot_done"},  64'(boot_done),  64'd0);
      check({tag, "_boot_error"}, 64'(boot_error), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      do_reset();
      check_reset_outputs("rst");

      // 1: autobaud byte, magic, 8 words
      send_byte(8'hFF);
      send_word(MAGIC);
      send_word(32'd8);
      for (int i = 0; i < 8; i++) expect_word(i, prog[i]);
      wait_writes(8, 20);
      check("t1_cpu_rst_n_at_last_write", 64'(cpu_rst_n), 64'd0);
      @(posedge clock); #2;
      check("t1_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
      check("t1_boot_done", 64'(boot_done), 64'd1);
      check("t1_mem_addr", 64'(mem_addr), 64'd8);
      // DONE ignores further bytes
      send_word(MAGIC);
      send_word(32'd1);
      send_word(32'h12345678);
      cycles(4);
      check("t1_done_mem_addr", 64'(mem_addr), 64'd8);
      check("t1_done_mem_we", 64'(mem_we), 64'd0);

      // 2: garbage plus overlapping partial magic
      do_reset();
      send_byte(8'h00); send_byte(8'h43); send_byte(8'h41); send_byte(8'h43);
      send_byte(8'h41); send_byte(8'h46); send_byte(8'h45);
      send_word(32'd1);
      expect_word(0, 32'hDEADBEEF);
      wait_writes(1, 20);
      cycles(2);
      check("t2_boot_done", 64'(boot_done), 64'd1);

      // 3: oversize count, then recovery
      do_reset();
      send_word(MAGIC);
      send_word(32'h00000401);
      cycles(3);
      check("t3_boot_error", 64'(boot_error), 64'd1);
      check("t3_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check("t3_mem_we", 64'(mem_we), 64'd0);
      send_word(MAGIC);
      check("t3_error_cleared", 64'(boot_error), 64'd0);
      send_word(32'd2);
      expect_word(0, 32'hA5A5_0001);
      expect_word(1, 32'h5A5A_0002);
      wait_writes(2, 20);
      cycles(2);
      check("t3_boot_done", 64'(boot_done), 64'd1);
      check("t3_boot_error_final", 64'(boot_error), 64'd0);

      // N = 0 goes straight to DONE
      do_reset();
      send_word(MAGIC);
      send_word(32'd0);
      cycles(3);
      check("n0_boot_done", 64'(boot_done), 64'd1);
      check("n0_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
      check("n0_writes", 64'(n_writes), 64'd0);

      // 4: overrun with mem_ready low, then a good load
      do_reset();
      mem_ready = 1'b0;
      send_word(MAGIC);
      send_word(32'd2);
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      cycles(3);
      check("t4_boot_error", 64'(boot_error), 64'd1);
      check("t4_mem_we", 64'(mem_we), 64'd0);
      check("t4_writes", 64'(n_writes), 64'd0);
      mem_ready = 1'b1;
      send_word(MAGIC);
      send_word(32'd2);
      expect_word(0, 32'h3333_3333);
      expect_word(1, 32'h4444_4444);
      wait_writes(2, 20);
      cycles(2);
      check("t4_boot_done", 64'(boot_done), 64'd1);

      // 5: idle timeout in DATA
      do_reset();
      send_word(MAGIC);
      send_word(32'd4);
      expect_word(0, 32'hCAFE_0000);
      expect_word(1, 32'hCAFE_0001);
      cycles(995);
      check("t5_no_early_timeout", 64'(boot_error), 64'd0);
      check("t5_writes", 64'(n_writes), 64'd2);
      cycles(10);
      check("t5_boot_error", 64'(boot_error), 64'd1);
      check("t5_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check("t5_mem_we", 64'(mem_we), 64'd0);
      send_word(MAGIC);
      send_word(32'd1);
      expect_word(0, 32'hBEEF_0005);
      wait_writes(3, 20);
      cycles(2);
      check("t5_recover_done", 64'(boot_done), 64'd1);

      // 6: async reset in the middle of word 3
      do_reset();
      send_word(MAGIC);
      send_word(32'd4);
      expect_word(0, 32'h0101_0101);
      expect_word(1, 32'h0202_0202);
      send_byte(8'h03);
      send_byte(8'h03);
      wait_writes(2, 20);
      @(posedge clock); #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      repeat (2) @(posedge clock);
      #1;
      reset    = 1'b1;
      n_writes = 0;
      send_word(MAGIC);
      send_word(32'd1);
      expect_word(0, 32'h0606_0606);
      wait_writes(1, 20);
      cycles(2);
      check("t6_boot_done", 64'(boot_done), 64'd1);

      check("final_queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
